// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      INIT      = 2'd0,
      RUN       = 2'd1,
      DMEM_WAIT = 2'd2,
      DRAIN     = 2'd3
   } state_e;

   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   localparam int DMEM_TIMEOUT_DEF = 16;
   localparam int TRAP_DRAIN_DEF   = 2;

   localparam stage_ctrl_t STAGE_RUN   = '{en: 1'b1, flush: 1'b0};
   localparam stage_ctrl_t STAGE_HOLD  = '{en: 1'b0, flush: 1'b0};
   localparam stage_ctrl_t STAGE_FLUSH = '{en: 1'b0, flush: 1'b1};
   // Flush wins over enable in the pipeline registers, so a killed stage may keep en=1.
   localparam stage_ctrl_t STAGE_KILL  = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        branch_taken;
   logic        imem_ready;
   logic        dmem_req;
   logic        dmem_ready;
   logic        trap_req;
   logic        pc_en;
   logic        if_id_en;
   logic        id_ex_en;
   logic        ex_mem_en;
   logic        mem_wb_en;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        ex_mem_flush;
   logic        mem_wb_flush;
   logic        trap_redirect;
   logic        bus_err;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             branch_taken, imem_ready, dmem_req, dmem_ready, trap_req,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
             trap_redirect, bus_err, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             branch_taken, imem_ready, dmem_req, dmem_ready, trap_req,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
             trap_redirect, bus_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose rd (not x0) is read by the ID instruction.
module hazard_detect (
   input  logic [4:0] idRs1_i,
   input  logic [4:0] idRs2_i,
   input  logic       idUseRs1_i,
   input  logic       idUseRs2_i,
   input  logic [4:0] exRd_i,
   input  logic       exMemRead_i,
   output logic       loadUse_o
);

   assign loadUse_o = exMemRead_i && (exRd_i != 5'd0) &&
                      ((idUseRs1_i && (idRs1_i == exRd_i)) ||
                       (idUseRs2_i && (idRs2_i == exRd_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline.
// Optional perf counters (stall_cnt/flush_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
   parameter int TRAP_DRAIN   = TRAP_DRAIN_DEF
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int WaitW  = $clog2(DMEM_TIMEOUT + 1);
   localparam int DrainW = (TRAP_DRAIN > 1) ? $clog2(TRAP_DRAIN) : 1;

   state_e              state_q, state_d;
   logic [WaitW-1:0]    waitCnt_q, waitCnt_d;
   logic [DrainW-1:0]   drainCnt_q, drainCnt_d;
   stage_ctrl_t         ifId, idEx, exMem, memWb;
   logic                pcEn, trapRedirect, busErr, loadUse;

   hazard_detect uHazard (
      .idRs1_i     (bus.id_rs1),
      .idRs2_i     (bus.id_rs2),
      .idUseRs1_i  (bus.id_use_rs1),
      .idUseRs2_i  (bus.id_use_rs2),
      .exRd_i      (bus.ex_rd),
      .exMemRead_i (bus.ex_mem_read),
      .loadUse_o   (loadUse)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         waitCnt_q  <= '0;
         drainCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         waitCnt_q  <= waitCnt_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   // Stage controls are a pure function of state and inputs; the RUN branches follow hazard priority.
   always_comb begin
      state_d      = state_q;
      waitCnt_d    = waitCnt_q;
      drainCnt_d   = drainCnt_q;
      pcEn         = 1'b1;
      ifId         = STAGE_RUN;
      idEx         = STAGE_RUN;
      exMem        = STAGE_RUN;
      memWb        = STAGE_RUN;
      trapRedirect = 1'b0;
      busErr       = 1'b0;
      unique case (state_q)
         INIT: begin
            pcEn  = 1'b0;
            ifId  = STAGE_FLUSH;
            idEx  = STAGE_FLUSH;
            exMem = STAGE_FLUSH;
            memWb = STAGE_FLUSH;
            state_d = RUN;
         end
         RUN: begin
            if (bus.trap_req) begin
               pcEn         = 1'b0;
               ifId         = STAGE_KILL;
               idEx         = STAGE_KILL;
               exMem        = STAGE_KILL;
               memWb        = STAGE_HOLD;
               trapRedirect = 1'b1;
               drainCnt_d   = DrainW'(TRAP_DRAIN - 1);
               state_d      = DRAIN;
            end else if (bus.dmem_req && !bus.dmem_ready) begin
               pcEn      = 1'b0;
               ifId      = STAGE_HOLD;
               idEx      = STAGE_HOLD;
               exMem     = STAGE_HOLD;
               memWb     = STAGE_KILL;
               waitCnt_d = WaitW'(1);
               state_d   = DMEM_WAIT;
            end else if (bus.branch_taken) begin
               ifId = STAGE_KILL;
               idEx = STAGE_KILL;
            end else if (loadUse) begin
               pcEn = 1'b0;
               ifId = STAGE_HOLD;
               idEx = STAGE_KILL;
            end else if (!bus.imem_ready) begin
               pcEn = 1'b0;
               ifId = STAGE_KILL;
            end
         end
         DMEM_WAIT: begin
            if (bus.dmem_ready) begin
               state_d = RUN;
            end else if (waitCnt_q == WaitW'(DMEM_TIMEOUT)) begin
               pcEn         = 1'b0;
               ifId         = STAGE_KILL;
               idEx         = STAGE_KILL;
               exMem        = STAGE_KILL;
               memWb        = STAGE_HOLD;
               trapRedirect = 1'b1;
               busErr       = 1'b1;
               drainCnt_d   = DrainW'(TRAP_DRAIN - 1);
               state_d      = DRAIN;
            end else begin
               pcEn      = 1'b0;
               ifId      = STAGE_HOLD;
               idEx      = STAGE_HOLD;
               exMem     = STAGE_HOLD;
               memWb     = STAGE_KILL;
               waitCnt_d = waitCnt_q + 1'b1;
            end
         end
         DRAIN: begin
            pcEn  = (drainCnt_q == '0);
            ifId  = STAGE_FLUSH;
            idEx  = STAGE_FLUSH;
            exMem = STAGE_FLUSH;
            memWb = STAGE_FLUSH;
            if (drainCnt_q == '0) begin
               state_d = RUN;
            end else begin
               drainCnt_d = drainCnt_q - 1'b1;
            end
         end
      endcase
   end

   assign bus.pc_en         = pcEn;
   assign bus.if_id_en      = ifId.en;
   assign bus.id_ex_en      = idEx.en;
   assign bus.ex_mem_en     = exMem.en;
   assign bus.mem_wb_en     = memWb.en;
   assign bus.if_id_flush   = ifId.flush;
   assign bus.id_ex_flush   = idEx.flush;
   assign bus.ex_mem_flush  = exMem.flush;
   assign bus.mem_wb_flush  = memWb.flush;
   assign bus.trap_redirect = trapRedirect;
   assign bus.bus_err       = busErr;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;
   logic        stallEvt, flushEvt;

   // In RUN only a taken branch keeps pc_en high while flushing IF/ID.
   assign stallEvt = !pcEn && ((state_q == RUN) || (state_q == DMEM_WAIT));
   assign flushEvt = trapRedirect || ((state_q == RUN) && pcEn && ifId.flush);

   always_comb begin
      stallCnt_d = stallCnt_q;
      flushCnt_d = flushCnt_q;
      if (stallEvt && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 32'd1;
      if (flushEvt && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign bus.stall_cnt = stallCnt_q;
   assign bus.flush_cnt = flushCnt_q;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif

endmodule
